// File: rtl/freq_lock_controller_pkg.sv
// rtl/freq_lock_controller_pkg.sv - shared state encoding, fault codes and helpers
package freq_lock_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_INC  = 2'd1,
    DIR_DEC  = 2'd2
  } dir_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_TIMEOUT  = 2'd1;
  localparam logic [1:0] FC_DIV_LOW  = 2'd2;
  localparam logic [1:0] FC_DIV_HIGH = 2'd3;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/freq_lock_controller_meas_classifier.sv
// rtl/freq_lock_controller_meas_classifier.sv - psi falling-edge detect and correction classification
module meas_classifier
  import freq_lock_controller_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic psi,
  input  logic inc,
  input  logic dec,
  output logic meas,
  output logic hit,
  output logic reversal,
  output logic drift
);

  logic psi_d;
  dir_t last_dir;
  dir_t cur_dir;
  logic corr;

  assign meas     = psi_d & ~psi;
  assign corr     = inc | dec;
  assign cur_dir  = inc ? DIR_INC : DIR_DEC;
  assign hit      = meas & ~corr;
  // With no recorded direction yet, a correction cannot be a reversal.
  assign reversal = meas & corr & (last_dir != DIR_NONE) & (cur_dir != last_dir);
  assign drift    = meas & corr & ~reversal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psi_d    <= 1'b0;
      last_dir <= DIR_NONE;
    end else begin
      psi_d <= psi;
      if (clear) begin
        last_dir <= DIR_NONE;
      end else if (meas && corr) begin
        last_dir <= cur_dir;
      end
    end
  end

endmodule

// File: rtl/freq_lock_controller.sv
// rtl/freq_lock_controller.sv - lock sequencing FSM and counters for the frequency regulator
module freq_lock_controller
  import freq_lock_controller_pkg::*;
#(
  parameter int LOCK_COUNT   = 8,
  parameter int LOSS_COUNT   = 4,
  parameter int TIMEOUT_MEAS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] target_period,
  input  logic       psi,
  input  logic       inc,
  input  logic       dec,
  input  logic [7:0] adj_div,
  output logic [7:0] set_period,
  output logic       reg_clear,
  output logic       reg_enable,
  output logic       locked,
  output logic       lock_lost,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state
);

  localparam logic [7:0] LOCK_TH    = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_TH    = 8'(LOSS_COUNT);
  localparam logic [7:0] TIMEOUT_TH = 8'(TIMEOUT_MEAS);

  state_t     cur;
  logic [7:0] meas_cnt;
  logic [7:0] settle_cnt;
  logic [7:0] drift_cnt;

  logic meas, hit, reversal, drift;
  logic settled;
  logic rail_low, rail_high;
  logic [7:0] meas_next, settle_next, drift_next;

  meas_classifier u_classifier (
    .clk      (clk),
    .rst      (rst),
    .clear    (cur == ST_CLEAR),
    .psi      (psi),
    .inc      (inc),
    .dec      (dec),
    .meas     (meas),
    .hit      (hit),
    .reversal (reversal),
    .drift    (drift)
  );

  assign settled     = hit | reversal;
  assign rail_low    = meas & dec & (adj_div == 8'h00);
  assign rail_high   = meas & inc & (adj_div == 8'hFF);
  assign meas_next   = sat_inc(meas_cnt);
  assign settle_next = settled ? sat_inc(settle_cnt) : 8'd0;
  assign drift_next  = sat_inc(drift_cnt);
  assign state       = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= ST_IDLE;
      set_period <= 8'd0;
      reg_clear  <= 1'b0;
      reg_enable <= 1'b0;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      meas_cnt   <= 8'd0;
      settle_cnt <= 8'd0;
      drift_cnt  <= 8'd0;
    end else begin
      reg_clear <= 1'b0;
      lock_lost <= 1'b0;
      if (abort) begin
        cur        <= ST_IDLE;
        reg_enable <= 1'b0;
        locked     <= 1'b0;
        fault      <= 1'b0;
        fault_code <= FC_NONE;
      end else begin
        case (cur)
          ST_IDLE, ST_FAULT: begin
            if (start) begin
              cur        <= ST_CLEAR;
              set_period <= target_period;
              reg_clear  <= 1'b1;
              fault      <= 1'b0;
              fault_code <= FC_NONE;
            end
          end

          ST_CLEAR: begin
            cur        <= ST_ACQUIRE;
            reg_enable <= 1'b1;
            meas_cnt   <= 8'd0;
            settle_cnt <= 8'd0;
            drift_cnt  <= 8'd0;
          end

          ST_ACQUIRE, ST_LOCKED: begin
            if (rail_low || rail_high) begin
              cur        <= ST_FAULT;
              reg_enable <= 1'b0;
              locked     <= 1'b0;
              fault      <= 1'b1;
              fault_code <= rail_low ? FC_DIV_LOW : FC_DIV_HIGH;
            end else if (meas && cur == ST_ACQUIRE) begin
              meas_cnt   <= meas_next;
              settle_cnt <= settle_next;
              // Lock is checked before timeout so a measurement satisfying both locks.
              if (settle_next >= LOCK_TH) begin
                cur       <= ST_LOCKED;
                locked    <= 1'b1;
                drift_cnt <= 8'd0;
              end else if (meas_next >= TIMEOUT_TH) begin
                cur        <= ST_FAULT;
                reg_enable <= 1'b0;
                fault      <= 1'b1;
                fault_code <= FC_TIMEOUT;
              end
            end else if (meas) begin
              if (!drift) begin
                drift_cnt <= 8'd0;
              end else if (drift_next >= LOSS_TH) begin
                cur        <= ST_ACQUIRE;
                locked     <= 1'b0;
                lock_lost  <= 1'b1;
                meas_cnt   <= 8'd0;
                settle_cnt <= 8'd0;
                drift_cnt  <= 8'd0;
              end else begin
                drift_cnt <= drift_next;
              end
            end
          end

          default: begin
            cur        <= ST_IDLE;
            reg_enable <= 1'b0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_lock_controller.sv
// tb/tb_freq_lock_controller.sv - directed vector bench for freq_lock_controller
module tb_freq_lock_controller;

  logic       clk = 1'b0;
  logic       rst, start, abort, psi, inc, dec;
  logic [7:0] target_period, adj_div;
  logic [7:0] set_period;
  logic       reg_clear, reg_enable, locked, lock_lost, fault;
  logic [1:0] fault_code;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  freq_lock_controller dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .target_period (target_period),
    .psi           (psi),
    .inc           (inc),
    .dec           (dec),
    .adj_div       (adj_div),
    .set_period    (set_period),
    .reg_clear     (reg_clear),
    .reg_enable    (reg_enable),
    .locked        (locked),
    .lock_lost     (lock_lost),
    .fault         (fault),
    .fault_code    (fault_code),
    .state         (state)
  );

  always #5 clk = ~clk;

  typedef enum {OP_NOP, OP_START, OP_ABORT, OP_MEAS} op_t;

  typedef struct {
    op_t        op;
    logic [7:0] arg;
    logic       i;
    logic       d;
    logic [2:0] e_st;
    logic       e_lk;
    logic       e_ll;
    logic       e_f;
    logic [1:0] e_fc;
    logic       e_en;
    logic       e_clr;
  } vec_t;

  vec_t vecs[$];

  // Packed as {state, locked, lock_lost, fault, fault_code, reg_enable, reg_clear}.
  function automatic logic [15:0] pack(input logic [2:0] st, input logic lk, input logic ll,
                                       input logic f, input logic [1:0] fc, input logic en,
                                       input logic clr);
    return {6'd0, st, lk, ll, f, fc, en, clr};
  endfunction

  function automatic logic [15:0] outs();
    return pack(state, locked, lock_lost, fault, fault_code, reg_enable, reg_clear);
  endfunction

  function automatic vec_t mk(input op_t op, input logic [7:0] arg, input logic i, input logic d,
                              input logic [2:0] st, input logic lk, input logic ll, input logic f,
                              input logic [1:0] fc, input logic en, input logic clr);
    vec_t v;
    v = '{op, arg, i, d, st, lk, ll, f, fc, en, clr};
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_meas(input logic i, input logic d);
    psi = 1'b1;
    tick();
    psi = 1'b0;
    inc = i;
    dec = d;
    tick();
    inc = 1'b0;
    dec = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] tp);
    target_period = tp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    psi = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    target_period = 8'd0;
    adj_div = 8'h80;

    // Lock on hits, loss on drift, then lock on alternating corrections.
    vecs.push_back(mk(OP_NOP,   8'd0,  0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0));
    vecs.push_back(mk(OP_START, 8'd40, 0, 0, 3'd1, 0, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(OP_NOP,   8'd0,  0, 0, 3'd2, 0, 0, 0, 2'd0, 1, 0));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(OP_MEAS, 8'd0, 0, 0, 3'd2, 0, 0, 0, 2'd0, 1, 0));
    vecs.push_back(mk(OP_MEAS,  8'd0,  0, 0, 3'd3, 1, 0, 0, 2'd0, 1, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(OP_MEAS, 8'd0, 1, 0, 3'd3, 1, 0, 0, 2'd0, 1, 0));
    vecs.push_back(mk(OP_MEAS,  8'd0,  1, 0, 3'd2, 0, 1, 0, 2'd0, 1, 0));
    vecs.push_back(mk(OP_NOP,   8'd0,  0, 0, 3'd2, 0, 0, 0, 2'd0, 1, 0));
    vecs.push_back(mk(OP_ABORT, 8'd0,  0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0));
    vecs.push_back(mk(OP_START, 8'd40, 0, 0, 3'd1, 0, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(OP_NOP,   8'd0,  0, 0, 3'd2, 0, 0, 0, 2'd0, 1, 0));
    vecs.push_back(mk(OP_MEAS,  8'd0,  1, 0, 3'd2, 0, 0, 0, 2'd0, 1, 0));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(OP_MEAS, 8'd0, k[0], ~k[0], 3'd2, 0, 0, 0, 2'd0, 1, 0));
    vecs.push_back(mk(OP_MEAS,  8'd0,  1, 0, 3'd3, 1, 0, 0, 2'd0, 1, 0));
    vecs.push_back(mk(OP_ABORT, 8'd0,  0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0));

    tick();
    tick();
    chk("reset_outs", outs(), pack(3'd0, 0, 0, 0, 2'd0, 0, 0));
    chk("reset_set_period", {8'd0, set_period}, 16'd0);
    rst = 1'b0;

    foreach (vecs[n]) begin
      case (vecs[n].op)
        OP_NOP:   tick();
        OP_START: do_start(vecs[n].arg);
        OP_ABORT: do_abort();
        default:  do_meas(vecs[n].i, vecs[n].d);
      endcase
      chk($sformatf("vec%0d", n), outs(),
          pack(vecs[n].e_st, vecs[n].e_lk, vecs[n].e_ll, vecs[n].e_f, vecs[n].e_fc,
               vecs[n].e_en, vecs[n].e_clr));
      if (vecs[n].op == OP_START)
        chk($sformatf("vec%0d_set_period", n), {8'd0, set_period}, {8'd0, vecs[n].arg});
    end

    // abort in the same cycle as start: no CLEAR, no reg_clear, period unchanged
    target_period = 8'd55;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_outs", outs(), pack(3'd0, 0, 0, 0, 2'd0, 0, 0));
    chk("abort_start_period", {8'd0, set_period}, 16'd40);

    // timeout after 200 drifting measurements
    do_start(8'd60);
    tick();
    for (int k = 0; k < 199; k++) do_meas(0, 1);
    chk("pre_timeout", outs(), pack(3'd2, 0, 0, 0, 2'd0, 1, 0));
    do_meas(0, 1);
    chk("timeout_fault", outs(), pack(3'd4, 0, 0, 1, 2'd1, 0, 0));
    do_start(8'd70);
    chk("restart_from_fault", outs(), pack(3'd1, 0, 0, 0, 2'd0, 0, 1));
    chk("restart_period", {8'd0, set_period}, 16'd70);
    tick();
    do_start(8'd99);
    chk("start_ignored", outs(), pack(3'd2, 0, 0, 0, 2'd0, 1, 0));
    chk("start_ignored_period", {8'd0, set_period}, 16'd70);

    // rail faults
    adj_div = 8'hFF;
    do_meas(1, 0);
    chk("rail_high", outs(), pack(3'd4, 0, 0, 1, 2'd3, 0, 0));
    do_start(8'd70);
    tick();
    adj_div = 8'h00;
    do_meas(0, 1);
    chk("rail_low", outs(), pack(3'd4, 0, 0, 1, 2'd2, 0, 0));
    adj_div = 8'h80;

    // lock and timeout on the same (200th) measurement: lock wins
    do_start(8'd30);
    tick();
    for (int k = 0; k < 192; k++) do_meas(0, 1);
    for (int k = 0; k < 7; k++) do_meas(0, 0);
    chk("pre_lock_vs_timeout", outs(), pack(3'd2, 0, 0, 0, 2'd0, 1, 0));
    do_meas(0, 0);
    chk("lock_beats_timeout", outs(), pack(3'd3, 1, 0, 0, 2'd0, 1, 0));

    // abort coincident with the locking measurement
    do_abort();
    do_start(8'd40);
    tick();
    for (int k = 0; k < 7; k++) do_meas(0, 0);
    psi = 1'b1;
    tick();
    psi = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_at_lock", outs(), pack(3'd0, 0, 0, 0, 2'd0, 0, 0));

    // asynchronous reset while locked
    do_start(8'd40);
    tick();
    for (int k = 0; k < 8; k++) do_meas(0, 0);
    chk("locked_before_reset", outs(), pack(3'd3, 1, 0, 0, 2'd0, 1, 0));
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outs", outs(), pack(3'd0, 0, 0, 0, 2'd0, 0, 0));
    chk("async_reset_period", {8'd0, set_period}, 16'd0);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_lock_controller.md
# freq_lock_controller

Sequencing controller for the frequency regulator. It latches a requested target period and drives the regulator's set-period input. It watches the regulator's per-pulse inc/dec decisions and its divider value, declares lock, detects loss of lock, and reports timeout or rail faults. It sits between the host/control interface and the regulator. The regulator's psi input, inc/dec outputs and adjusted divider feed back into this block.

## Interface
- LOCK_COUNT, 8: consecutive settled measurements required to declare lock (1..255).
- LOSS_COUNT, 4: consecutive same-direction corrections in LOCKED that drop lock (1..255).
- TIMEOUT_MEAS, 200: maximum measurements allowed in ACQUIRE before fault (1..255).
- clk  in  1  system clock, same clock as the regulator.
- rst  in  1  reset rst, asynchronous, active-high.
- start  in  1  single-cycle request; honoured in IDLE and FAULT.
- abort  in  1  return to IDLE from any state.
- target_period  in  8  requested psi-high duration in clk cycles; sampled only on an accepted start.
- psi  in  1  same psi signal that feeds the regulator.
- inc  in  1  regulator increment decision, valid in the psi falling-edge cycle.
- dec  in  1  regulator decrement decision, valid in the psi falling-edge cycle.
- adj_div  in  8  regulator's adjusted divider.
- set_period  out  8  registered period driven to the regulator.
- reg_clear  out  1  one-cycle pulse requesting the regulator be re-initialised.
- reg_enable  out  1  high in ACQUIRE and LOCKED.
- locked  out  1  high only in LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED→ACQUIRE transition.
- fault  out  1  high in FAULT.
- fault_code  out  2  0 none, 1 timeout, 2 divider at 0, 3 divider at 255.
- state  out  3  current state encoding, for debug.

## Operation
- Internal psi_d register. A measurement event `meas` is psi_d=1 and psi=0. inc and dec are sampled in that same cycle; this matches the regulator's own edge alignment.
- Measurement classes:
  - hit: inc=0 and dec=0.
  - reversal: correction opposite to the last recorded correction direction.
  - drift: correction in the same direction as the last recorded one.
  - The first correction after CLEAR counts as drift.
- A settled measurement is a hit or a reversal. Every correction updates last_dir.
- States and transitions:
  - IDLE: outputs quiet. On start: latch target_period into set_period and go to CLEAR.
  - CLEAR, one cycle: reg_clear=1; zero all counters and last_dir. Next state is ACQUIRE.
  - ACQUIRE: on each meas, increment meas_cnt (saturating at 255).
    - Settled: settle_cnt+1. Drift: settle_cnt=0.
    - If settle_cnt reaches LOCK_COUNT, go to LOCKED.
    - Otherwise, if meas_cnt reaches TIMEOUT_MEAS, go to FAULT with code 1.
  - LOCKED: on each meas, drift increments drift_cnt and settled clears it.
    - When drift_cnt reaches LOSS_COUNT: pulse lock_lost, clear settle_cnt, meas_cnt and drift_cnt, and go to ACQUIRE.
  - FAULT: reg_enable=0; fault and fault_code held. start goes to CLEAR, which also clears fault_code.
- Rail check, in ACQUIRE and LOCKED on any cycle: adj_div=8'h00 with dec=1 at meas, go to FAULT code 2; adj_div=8'hFF with inc=1 at meas, go to FAULT code 3.
- Priority in one cycle: abort > rail fault > lock/loss/timeout decision.
- The lock decision and the timeout fire on the same meas: lock wins.
- start outside IDLE/FAULT is ignored. target_period changes have no effect until the next accepted start.
- Counters are 8-bit and saturate; they never wrap.

## Timing
- Reset values: all outputs 0, state IDLE, psi_d 0.
- start in cycle N: CLEAR in N+1, with reg_clear and the new set_period visible then. ACQUIRE in N+2, reg_enable=1.
- The meas that completes the lock count: locked=1 in the following cycle.
- lock_lost pulses for exactly the cycle state first shows ACQUIRE.
- Fault conditions register in one cycle.
- abort: IDLE in the next cycle. A one-cycle CLEAR-in-progress is cut off with no reg_clear pulse.
- Asynchronous reset in any state: immediately IDLE with all outputs 0.

## Structure
- Shared package holds the state encoding (IDLE=0, CLEAR=1, ACQUIRE=2, LOCKED=3, FAULT=4) and the fault_code constants.
- One natural sub-module, `meas_classifier`: holds psi_d and last_dir, and outputs meas, hit, reversal and drift. The FSM and counters stay in the top level.

## Test plan
- Reset, then start with target_period=40 and hit on 8 consecutive meas → CLEAR one cycle after start, locked=1 the cycle after the 8th meas.
- Corrections inc, dec, inc, dec… from the 2nd correction onward → lock after 8 reversals. The initial inc is drift and does not count.
- LOCKED, then 4 consecutive inc corrections → lock_lost one-cycle pulse, state ACQUIRE, locked=0.
- ACQUIRE with 200 consecutive dec corrections and adj_div>0 → fault=1, fault_code=1. Then start → CLEAR and fault cleared.
- adj_div=8'hFF with inc at meas → FAULT, code 3. adj_div=0 with dec at meas → FAULT, code 2.
- abort asserted in the same cycle as the locking meas → IDLE, locked stays 0. Reset mid-LOCKED → all outputs 0 immediately.
